// File: rtl/diff_event_monitor.sv
// Watches the comparator "differ" flag: saturating sample/mismatch totals, consecutive
// mismatch run length, and an alarm FSM with hysteresis on release.
module diff_event_monitor #(
    parameter int CNT_W     = 8,
    parameter int RUN_LIMIT = 3,
    parameter int RELEASE   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             s,
    input  logic             clear,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] diff_cnt,
    output logic [CNT_W-1:0] run_len,
    output logic             alarm,
    output logic             alarm_pulse,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        DIFF  = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(RUN_LIMIT);
    localparam logic [CNT_W-1:0] REL_CNT   = CNT_W'(RELEASE);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + CNT_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] match_inc;
    logic             alarm_q, alarm_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        diff_d    = diff_q;
        run_d     = run_q;
        match_d   = match_q;
        match_inc = sat_inc(match_q);
        pulse_d   = 1'b0;
        if (in_valid) begin
            total_d = sat_inc(total_q);
            if (s) begin
                diff_d = sat_inc(diff_q);
                run_d  = sat_inc(run_q);
            end else begin
                run_d  = '0;
            end
            // Alarm decision uses the run length that includes this sample.
            case (state_q)
                ALARM: begin
                    if (s) begin
                        match_d = '0;
                    end else if (match_inc >= REL_CNT) begin
                        state_d = MATCH;
                        match_d = '0;
                    end else begin
                        match_d = match_inc;
                    end
                end
                default: begin
                    match_d = '0;
                    if (s) state_d = (run_d >= LIMIT_CNT) ? ALARM : DIFF;
                    else   state_d = MATCH;
                end
            endcase
            pulse_d = (state_d == ALARM) && (state_q != ALARM);
        end
        alarm_d = (state_d == ALARM);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= IDLE;
            total_q <= '0;
            diff_q  <= '0;
            run_q   <= '0;
            match_q <= '0;
            alarm_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            diff_q  <= diff_d;
            run_q   <= run_d;
            match_q <= match_d;
            alarm_q <= alarm_d;
            pulse_q <= pulse_d;
        end
    end

    assign total_cnt   = total_q;
    assign diff_cnt    = diff_q;
    assign run_len     = run_q;
    assign alarm       = alarm_q;
    assign alarm_pulse = pulse_q;
    assign state       = state_q;

endmodule

// File: tb/tb_diff_event_monitor.sv
// Directed bench for diff_event_monitor: default instance plus a CNT_W=4 instance for saturation.
module tb_diff_event_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_valid, s, clear;
    logic [7:0] total_cnt, diff_cnt, run_len;
    logic       alarm, alarm_pulse;
    logic [1:0] state;

    logic       reset4, in_valid4, s4, clear4;
    logic [3:0] total4, diff4, run4;
    logic       alarm4, pulse4;
    logic [1:0] state4;

    int compared   = 0;
    int mismatched = 0;

    diff_event_monitor dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .s(s), .clear(clear),
        .total_cnt(total_cnt), .diff_cnt(diff_cnt), .run_len(run_len),
        .alarm(alarm), .alarm_pulse(alarm_pulse), .state(state)
    );

    diff_event_monitor #(.CNT_W(4), .RUN_LIMIT(3), .RELEASE(2)) dut4 (
        .clk(clk), .reset(reset4), .in_valid(in_valid4), .s(s4), .clear(clear4),
        .total_cnt(total4), .diff_cnt(diff4), .run_len(run4),
        .alarm(alarm4), .alarm_pulse(pulse4), .state(state4)
    );

    task automatic step(input logic v, input logic sv, input logic c, input logic r);
        @(negedge clk);
        in_valid = v;
        s        = sv;
        clear    = c;
        reset    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic v, input logic sv);
        @(negedge clk);
        in_valid4 = v;
        s4        = sv;
        clear4    = 1'b0;
        reset4    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [7:0] t, input logic [7:0] d,
                             input logic [7:0] r, input logic [1:0] st, input logic a,
                             input logic p);
        compared++;
        if ({total_cnt, diff_cnt, run_len, state, alarm, alarm_pulse} !== {t, d, r, st, a, p}) begin
            mismatched++;
            $display("FAIL %s: got total=%0d diff=%0d run=%0d state=%0d alarm=%b pulse=%b, expected total=%0d diff=%0d run=%0d state=%0d alarm=%b pulse=%b",
                     name, total_cnt, diff_cnt, run_len, state, alarm, alarm_pulse, t, d, r, st, a, p);
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_all("reset_state", 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_all("reset_release_idle", 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_matches();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("five_matches", 8'd5, 8'd0, 8'd0, 2'd1, 1'b0, 1'b0);
    endtask

    task automatic test_alarm_entry();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_all("clear_before_entry", 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("diff_1", 8'd1, 8'd1, 8'd1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("diff_2", 8'd2, 8'd2, 8'd2, 2'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("alarm_enter", 8'd3, 8'd3, 8'd3, 2'd3, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_all("pulse_one_cycle", 8'd3, 8'd3, 8'd3, 2'd3, 1'b1, 1'b0);
    endtask

    task automatic test_release();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("rel_s0_a", 8'd4, 8'd3, 8'd0, 2'd3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("rel_s1_resets_match", 8'd5, 8'd4, 8'd1, 2'd3, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("rel_s0_b", 8'd6, 8'd4, 8'd0, 2'd3, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("rel_release", 8'd7, 8'd4, 8'd0, 2'd1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("reentry_pre", 8'd9, 8'd6, 8'd2, 2'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("reentry_pulse", 8'd10, 8'd7, 8'd3, 2'd3, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("stay_alarm_no_pulse", 8'd11, 8'd8, 8'd4, 2'd3, 1'b1, 1'b0);
    endtask

    task automatic test_gap();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("gap_first", 8'd1, 8'd1, 8'd1, 2'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_all("gap_hold", 8'd1, 8'd1, 8'd1, 2'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_all("gap_hold2", 8'd1, 8'd1, 8'd1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("gap_second", 8'd2, 8'd2, 8'd2, 2'd2, 1'b0, 1'b0);
    endtask

    task automatic test_clear_reset_in_alarm();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("alarm_before_clear", 8'd5, 8'd5, 8'd5, 2'd3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_all("clear_in_alarm", 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("alarm_before_reset", 8'd3, 8'd3, 8'd3, 2'd3, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_all("reset_in_alarm", 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_saturate();
        int pulses;
        pulses = 0;
        @(negedge clk);
        reset4 = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            step4(1'b1, 1'b1);
            if (pulse4 === 1'b1) pulses++;
        end
        compared++;
        if ({total4, diff4, run4, state4, alarm4} !== {4'd15, 4'd15, 4'd15, 2'd3, 1'b1}) begin
            mismatched++;
            $display("FAIL sat_counts: got total=%0d diff=%0d run=%0d state=%0d alarm=%b, expected 15 15 15 3 1",
                     total4, diff4, run4, state4, alarm4);
        end
        compared++;
        if (pulses !== 1) begin
            mismatched++;
            $display("FAIL sat_pulse_count: got %0d pulses, expected 1", pulses);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; s = 1'b0; clear = 1'b0;
        reset4 = 1'b1; in_valid4 = 1'b0; s4 = 1'b0; clear4 = 1'b0;
        test_reset();
        test_matches();
        test_alarm_entry();
        test_release();
        test_back_to_back();
        test_gap();
        test_clear_reset_in_alarm();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
